sort_result_unloader: RTL

Output stage of the bitonic sorting network. It captures the full parallel result vector on the cycle the final compare-exchange column raises `done`, then streams the elements out one per transfer on a valid/ready interface. It reports busy status and drops, with a count, any result that arrives while a previous one is still draining.

---
 rtl/sort_result_unloader.sv | 67 ++++++
 1 files changed

// File: rtl/sort_result_unloader.sv
// sort_result_unloader: captures a sorted vector on done and streams it out over valid/ready,
// dropping and counting any done that arrives while a vector is still draining.
module sort_result_unloader #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 8,
  parameter int ORDER      = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             done,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0]  data_in,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic                             busy,
  output logic                             overflow,
  output logic [7:0]                       drop_cnt
);
  localparam int IW = $clog2(NUM_ELEMS);
  localparam logic [IW-1:0] FIRST = (ORDER != 0) ? IW'(NUM_ELEMS - 1) : '0;
  localparam logic [IW-1:0] FINAL = (ORDER != 0) ? '0 : IW'(NUM_ELEMS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_next;
  logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] r_buf;
  logic [IW-1:0] r_idx;
  logic r_ovf;
  logic [7:0] r_drop;
  logic w_xfer, w_last, w_cap, w_drop;
  assign w_xfer = (r_state == SEND) && out_ready;
  assign w_last = r_idx == FINAL;
  // a done coinciding with the final transfer chains the next vector without a bubble
  assign w_cap  = done && ((r_state == IDLE) || (w_xfer && w_last));
  assign w_drop = done && (r_state == SEND) && !(w_xfer && w_last);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (done ? SEND : IDLE)
                               : ((w_xfer && w_last && !done) ? IDLE : SEND);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      r_ovf <= w_drop;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (w_cap) begin
        r_buf <= data_in;
        r_idx <= FIRST;
      end else if (w_xfer && !w_last) begin
        r_idx <= (ORDER != 0) ? r_idx - 1'b1 : r_idx + 1'b1;
      end
    end
  end
  assign busy      = r_state == SEND;
  assign out_valid = busy;
  assign out_data  = busy ? r_buf[r_idx] : '0;
  assign out_last  = busy && w_last;
  assign overflow  = r_ovf;
  assign drop_cnt  = r_drop;
endmodule
